// File: rtl/mesi_isc_fifo_pkg.sv
// Shared constants and helpers for the parameterised MESI ISC FIFO.
package mesi_isc_fifo_pkg;

  // Default geometry of the FIFO.
  localparam int FIFO_DATA_WIDTH_DEF = 32;
  localparam int FIFO_SIZE_DEF       = 4;
  localparam int FIFO_SIZE_LOG2_DEF  = 2;
  localparam int FIFO_AEMPTY_THR_DEF = 1;

  // Widest pointer the count helper supports (FIFO_SIZE_LOG2 + 1 must be below this).
  localparam int FIFO_PTR_MAX_W = 16;

  typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

  // Occupancy from two zero-extended wrap-bit pointers. The caller keeps the
  // low FIFO_SIZE_LOG2+1 bits, which gives the difference modulo the pointer
  // range, so a full FIFO reads as FIFO_SIZE rather than 0.
  function automatic fifo_ptr_t fifo_count(input fifo_ptr_t ptr_wr,
                                           input fifo_ptr_t ptr_rd);
    return ptr_wr - ptr_rd;
  endfunction

endpackage

// File: rtl/mesi_isc_fifo_ptr.sv
// Wrap-bit FIFO pointer: the low bits index an entry, the MSB flips on each
// pass through the storage. Clear has priority over increment.
module mesi_isc_fifo_ptr
  import mesi_isc_fifo_pkg::*;
#(
  parameter int PTR_W = FIFO_SIZE_LOG2_DEF + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Pointer register; wraps naturally through the full PTR_W range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/mesi_isc_param_fifo.sv
// Parameterised first-word-fall-through FIFO with registered-pointer status,
// synchronous flush and sticky overflow/underflow flags.
module mesi_isc_param_fifo
  import mesi_isc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = FIFO_DATA_WIDTH_DEF,
  parameter int FIFO_SIZE      = FIFO_SIZE_DEF,
  parameter int FIFO_SIZE_LOG2 = FIFO_SIZE_LOG2_DEF,
  parameter int AFULL_THR      = FIFO_SIZE - 1,
  parameter int AEMPTY_THR     = FIFO_AEMPTY_THR_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    clr_err_i,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    status_empty_o,
  output logic                    status_full_o,
  output logic                    status_afull_o,
  output logic                    status_aempty_o,
  output logic [FIFO_SIZE_LOG2:0] count_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int PW = FIFO_SIZE_LOG2 + 1;

  logic [PW-1:0]             ptr_wr;
  logic [PW-1:0]             ptr_rd;
  logic [FIFO_SIZE_LOG2-1:0] wr_idx;
  logic [FIFO_SIZE_LOG2-1:0] rd_idx;
  logic                      empty;
  logic                      full;
  logic                      rd_acc;
  logic                      wr_acc;
  logic                      rd_go;
  logic                      wr_go;
  logic                      ovf_set;
  logic                      unf_set;
  logic [DATA_WIDTH-1:0]     mem [FIFO_SIZE];
  logic [DATA_WIDTH-1:0]     last_head;
  fifo_ptr_t                 cnt_wide;
  logic [31:0]               cnt_ext;
  logic                      unused_cnt_hi;

  assign wr_idx = ptr_wr[FIFO_SIZE_LOG2-1:0];
  assign rd_idx = ptr_rd[FIFO_SIZE_LOG2-1:0];

  // Empty/full decode straight from the registered pointers.
  assign empty = (ptr_wr == ptr_rd);
  assign full  = (wr_idx == rd_idx) && (ptr_wr[PW-1] != ptr_rd[PW-1]);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write
  // alongside it; an empty FIFO never forwards the incoming write to the read.
  assign rd_acc = rd_i && !empty;
  assign wr_acc = wr_i && (!full || rd_acc);

  // Flush discards both requests for the cycle it is asserted.
  assign rd_go = rd_acc && !flush_i;
  assign wr_go = wr_acc && !flush_i;

  // Errors are only flagged for requests that are actually refused, not for
  // ones dropped by a flush.
  assign ovf_set = wr_i && !wr_acc && !flush_i;
  assign unf_set = rd_i && !rd_acc && !flush_i;

  mesi_isc_fifo_ptr #(.PTR_W(PW)) u_ptr_wr (
    .clk (clk),
    .rst (rst),
    .clr (flush_i),
    .inc (wr_go),
    .ptr (ptr_wr)
  );

  mesi_isc_fifo_ptr #(.PTR_W(PW)) u_ptr_rd (
    .clk (clk),
    .rst (rst),
    .clr (flush_i),
    .inc (rd_go),
    .ptr (ptr_rd)
  );

  // Entry storage; cleared on reset so no stale data is ever visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_go) begin
      mem[wr_idx] <= data_i;
    end
  end

  // Remembers the head shown last cycle so data_o holds it once the FIFO drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_head <= '0;
    end else begin
      last_head <= data_o;
    end
  end

  assign data_o = empty ? last_head : mem[rd_idx];

  // Occupancy and threshold flags.
  assign cnt_wide      = fifo_count(fifo_ptr_t'(ptr_wr), fifo_ptr_t'(ptr_rd));
  assign count_o       = cnt_wide[PW-1:0];
  assign unused_cnt_hi = ^cnt_wide[FIFO_PTR_MAX_W-1:PW];
  assign cnt_ext       = 32'(count_o);

  assign status_empty_o  = empty;
  assign status_full_o   = full;
  assign status_afull_o  = (cnt_ext >= $unsigned(AFULL_THR));
  assign status_aempty_o = (cnt_ext <= $unsigned(AEMPTY_THR));

  // Sticky overflow flag; a new error beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_o <= 1'b0;
    end else if (ovf_set) begin
      overflow_o <= 1'b1;
    end else if (clr_err_i) begin
      overflow_o <= 1'b0;
    end
  end

  // Sticky underflow flag; a new error beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_o <= 1'b0;
    end else if (unf_set) begin
      underflow_o <= 1'b1;
    end else if (clr_err_i) begin
      underflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mesi_isc_param_fifo.sv
// Directed testbench for mesi_isc_param_fifo (default parameters: 32-bit, 4 entries).
module tb_mesi_isc_param_fifo;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        clr_err_i;
  logic        wr_i;
  logic        rd_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        status_empty_o;
  logic        status_full_o;
  logic        status_afull_o;
  logic        status_aempty_o;
  logic [2:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  int n_cmp;
  int n_err;

  mesi_isc_param_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .clr_err_i       (clr_err_i),
    .wr_i            (wr_i),
    .rd_i            (rd_i),
    .data_i          (data_i),
    .data_o          (data_o),
    .status_empty_o  (status_empty_o),
    .status_full_o   (status_full_o),
    .status_afull_o  (status_afull_o),
    .status_aempty_o (status_aempty_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o),
    .underflow_o     (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush_i   = 1'b0;
    clr_err_i = 1'b0;
    wr_i      = 1'b0;
    rd_i      = 1'b0;
    data_i    = 32'h0;
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0t wr=%0b rd=%0b fl=%0b din=%h -> dout=%h cnt=%0d e=%0b f=%0b ovf=%0b unf=%0b",
             $time, wr_i, rd_i, flush_i, data_i, data_o, count_o, status_empty_o,
             status_full_o, overflow_o, underflow_o);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #22;
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (status_empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b want 1", status_empty_o); end
    n_cmp++; if (status_aempty_o !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %0b want 1", status_aempty_o); end
    n_cmp++; if (status_full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", status_full_o); end
    n_cmp++; if (status_afull_o !== 1'b0) begin n_err++; $display("FAIL reset_afull got %0b want 0", status_afull_o); end
    n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow_o); end
    n_cmp++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL reset_unf got %0b want 0", underflow_o); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      wr_i   = 1'b1;
      data_i = 32'hA1 + i;
      tick();
      n_cmp++; if (count_o !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count_o, i + 1); end
      n_cmp++; if (data_o !== 32'hA1) begin n_err++; $display("FAIL fill_head[%0d] got %h want a1", i, data_o); end
    end
    idle();
    n_cmp++; if (status_full_o !== 1'b1) begin n_err++; $display("FAIL fill_full got %0b want 1", status_full_o); end
    n_cmp++; if (status_afull_o !== 1'b1) begin n_err++; $display("FAIL fill_afull got %0b want 1", status_afull_o); end
    n_cmp++; if (status_aempty_o !== 1'b0) begin n_err++; $display("FAIL fill_aempty got %0b want 0", status_aempty_o); end
  endtask

  task automatic test_overflow();
    wr_i   = 1'b1;
    data_i = 32'hFF;
    tick();
    idle();
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", overflow_o); end
    n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", count_o); end
    n_cmp++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_unf got %0b want 0", underflow_o); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (data_o !== 32'hA1 + i) begin n_err++; $display("FAIL ovf_read[%0d] got %h want %h", i, data_o, 32'hA1 + i); end
      rd_i = 1'b1;
      tick();
      n_cmp++; if (count_o !== 3'(3 - i)) begin n_err++; $display("FAIL ovf_drain_count[%0d] got %0d want %0d", i, count_o, 3 - i); end
    end
    idle();
    n_cmp++; if (status_empty_o !== 1'b1) begin n_err++; $display("FAIL ovf_empty got %0b want 1", status_empty_o); end
    n_cmp++; if (data_o !== 32'hA4) begin n_err++; $display("FAIL ovf_hold got %h want a4", data_o); end
  endtask

  task automatic test_simul_empty();
    clr_err_i = 1'b1;
    tick();
    idle();
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %0b want 0", overflow_o); end
    wr_i   = 1'b1;
    rd_i   = 1'b1;
    data_i = 32'h55;
    tick();
    idle();
    n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL simul_count got %0d want 1", count_o); end
    n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL simul_unf got %0b want 1", underflow_o); end
    n_cmp++; if (data_o !== 32'h55) begin n_err++; $display("FAIL simul_data got %h want 55", data_o); end
    rd_i      = 1'b1;
    clr_err_i = 1'b1;
    tick();
    idle();
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL simul_drain got %0d want 0", count_o); end
    n_cmp++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL simul_clr got %0b want 0", underflow_o); end
    n_cmp++; if (data_o !== 32'h55) begin n_err++; $display("FAIL simul_hold got %h want 55", data_o); end
  endtask

  task automatic test_full_rdwr();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'hC1;
    exp_rd[1] = 32'hC2;
    exp_rd[2] = 32'hC3;
    exp_rd[3] = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      wr_i   = 1'b1;
      data_i = 32'hC0 + i;
      tick();
    end
    idle();
    n_cmp++; if (status_full_o !== 1'b1) begin n_err++; $display("FAIL frw_full_pre got %0b want 1", status_full_o); end
    wr_i   = 1'b1;
    rd_i   = 1'b1;
    data_i = 32'hB0;
    tick();
    idle();
    n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL frw_count got %0d want 4", count_o); end
    n_cmp++; if (status_full_o !== 1'b1) begin n_err++; $display("FAIL frw_full got %0b want 1", status_full_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL frw_ovf got %0b want 0", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (data_o !== exp_rd[i]) begin n_err++; $display("FAIL frw_read[%0d] got %h want %h", i, data_o, exp_rd[i]); end
      rd_i = 1'b1;
      tick();
    end
    idle();
    n_cmp++; if (status_empty_o !== 1'b1) begin n_err++; $display("FAIL frw_empty got %0b want 1", status_empty_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] q [$];
    int          nwr;
    bit          do_rd;
    nwr = 0;
    for (int k = 0; k < 20; k++) begin
      do_rd = (k >= 17) || ((k >= 3) && ((k - 3) % 2 == 0));
      if (do_rd) begin
        n_cmp++; if (data_o !== q[0]) begin n_err++; $display("FAIL wrap_read[%0d] got %h want %h", k, data_o, q[0]); end
        rd_i = 1'b1;
        void'(q.pop_front());
      end else begin
        wr_i   = 1'b1;
        data_i = 32'hD0 + nwr;
        q.push_back(32'hD0 + nwr);
        nwr++;
      end
      tick();
      idle();
      n_cmp++; if (count_o !== 3'(q.size())) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want %0d", k, count_o, q.size()); end
      n_cmp++; if (status_afull_o !== (q.size() >= 3)) begin n_err++; $display("FAIL wrap_afull[%0d] got %0b want %0b", k, status_afull_o, q.size() >= 3); end
      n_cmp++; if (status_aempty_o !== (q.size() <= 1)) begin n_err++; $display("FAIL wrap_aempty[%0d] got %0b want %0b", k, status_aempty_o, q.size() <= 1); end
    end
  endtask

  task automatic test_flush_and_reset();
    rd_i = 1'b1;
    tick();
    idle();
    n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL fl_unf_set got %0b want 1", underflow_o); end
    for (int i = 0; i < 3; i++) begin
      wr_i   = 1'b1;
      data_i = 32'hE0 + i;
      tick();
    end
    idle();
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL fl_count_pre got %0d want 3", count_o); end
    flush_i = 1'b1;
    wr_i    = 1'b1;
    data_i  = 32'hEE;
    tick();
    idle();
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL fl_count got %0d want 0", count_o); end
    n_cmp++; if (status_empty_o !== 1'b1) begin n_err++; $display("FAIL fl_empty got %0b want 1", status_empty_o); end
    n_cmp++; if (underflow_o !== 1'b1) begin n_err++; $display("FAIL fl_unf_kept got %0b want 1", underflow_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fl_ovf_kept got %0b want 0", overflow_o); end
    wr_i   = 1'b1;
    data_i = 32'hF0;
    tick();
    wr_i   = 1'b1;
    data_i = 32'hF1;
    tick();
    idle();
    n_cmp++; if (data_o !== 32'hF0) begin n_err++; $display("FAIL fl_after_head got %h want f0", data_o); end
    n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL fl_after_count got %0d want 2", count_o); end
    wr_i   = 1'b1;
    data_i = 32'hF2;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", count_o); end
    n_cmp++; if (status_empty_o !== 1'b1) begin n_err++; $display("FAIL arst_empty got %0b want 1", status_empty_o); end
    n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL arst_data got %h want 0", data_o); end
    n_cmp++; if (underflow_o !== 1'b0) begin n_err++; $display("FAIL arst_unf got %0b want 0", underflow_o); end
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL arst_release_count got %0d want 0", count_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_simul_empty();
    test_full_rdwr();
    test_wrap();
    test_flush_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mesi_isc_param_fifo.md
MESI_ISC_PARAM_FIFO -- requirements
Module: mesi_isc_param_fifo

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the entry width in bits.
REQ-003 Parameter FIFO_SIZE, default 4, SHALL set the entry count, a power of two >= 2.
REQ-004 Parameter FIFO_SIZE_LOG2, default 2, SHALL equal log2(FIFO_SIZE).
REQ-005 Parameter AFULL_THR, default FIFO_SIZE-1, SHALL set the almost-full level.
REQ-006 Parameter AEMPTY_THR, default 1, SHALL set the almost-empty level.
REQ-007 The ports SHALL be, in this order:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush_i  in  1  synchronous discard of all entries.
- clr_err_i  in  1  clears the sticky error flags.
- wr_i  in  1  write request.
- rd_i  in  1  read request; pops the head entry.
- data_i  in  DATA_WIDTH  write data.
- data_o  out  DATA_WIDTH  head entry, first-word-fall-through.
- status_empty_o  out  1  count == 0.
- status_full_o  out  1  count == FIFO_SIZE.
- status_afull_o  out  1  count >= AFULL_THR.
- status_aempty_o  out  1  count <= AEMPTY_THR.
- count_o  out  FIFO_SIZE_LOG2+1  number of valid entries, 0..FIFO_SIZE.
- overflow_o  out  1  sticky flag: a write was rejected.
- underflow_o  out  1  sticky flag: a read was rejected.

Function
REQ-008 Read and write pointers SHALL each be FIFO_SIZE_LOG2+1 bits: the low bits index the entry and the MSB is the wrap bit.
REQ-009 Empty SHALL mean the pointers are equal; full SHALL mean the low bits are equal and the MSBs differ.
REQ-010 count_o SHALL equal ptr_wr - ptr_rd modulo 2^(FIFO_SIZE_LOG2+1), and SHALL never alias full as 0.
REQ-011 A write SHALL be accepted when wr_i=1 and (not full, or a read is accepted in the same cycle).
REQ-012 An accepted write SHALL store data_i at ptr_wr and increment ptr_wr.
REQ-013 A read SHALL be accepted when rd_i=1 and not empty; an accepted read SHALL increment ptr_rd.
REQ-014 On an empty FIFO with wr_i=1 and rd_i=1, the write SHALL be accepted, the read rejected and underflow_o set.
REQ-015 On a full FIFO with wr_i=1 and rd_i=1, both SHALL be accepted and count SHALL stay at FIFO_SIZE.
REQ-016 A rejected write (wr_i=1, full, no accepted read) SHALL leave storage unchanged and set overflow_o.
REQ-017 data_o SHALL be entry[ptr_rd], visible one cycle after the write that filled an empty FIFO, with no rd_i needed.
REQ-018 data_o SHALL hold the last head value while empty and SHALL update the cycle after each accepted read.
REQ-019 All status outputs SHALL be decoded from the registered pointers, so they are valid the cycle after the event.
REQ-020 flush_i=1 SHALL set both pointers to 0 at the next edge, with priority over wr_i and rd_i in that cycle; entry contents are don't-care.
REQ-021 Sticky flags SHALL be unaffected by flush_i.
REQ-022 clr_err_i=1 SHALL clear both sticky flags; a new error in the same cycle SHALL win.
REQ-023 Pointers SHALL wrap naturally, with no special casing at the index FIFO_SIZE-1 to 0 transition.

Reset
REQ-024 While rst=0, the pointers, count_o, data_o, all entries, overflow_o and underflow_o SHALL be 0.
REQ-025 While rst=0, status_empty_o=1, status_aempty_o=1 and status_full_o=0; status_afull_o=0 when AFULL_THR>0.
REQ-026 Reset asserted mid-operation SHALL discard all contents immediately, regardless of the clock.

Structure
REQ-027 Package mesi_isc_fifo_pkg SHALL hold the default parameter constants and a function computing count from two pointers.
REQ-028 One sub-module, mesi_isc_fifo_ptr, SHALL implement a wrap-bit pointer with increment and clear; it is instantiated twice.

Verification
REQ-029 After reset, write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> full=1 and count_o=4; data_o=0xA1 from the cycle after the first write.
REQ-030 Full FIFO, wr_i=1 with data 0xFF and rd_i=0 -> overflow_o=1, count_o stays 4, and subsequent reads return 0xA1..0xA4 in order.
REQ-031 Empty FIFO, wr_i=1 (0x55) and rd_i=1 together -> count_o=1, underflow_o=1, data_o=0x55 next cycle.
REQ-032 Full FIFO, simultaneous read and write of 0xB0 -> count_o stays 4, the head advances, and 0xB0 is returned as the fourth read.
REQ-033 Write 10 entries with reads interleaved (wrap twice) -> read data equals write order; afull/aempty toggle exactly at counts 3 and 1.
REQ-034 Count 3 with flush_i=1 and wr_i=1 together -> count_o=0 and empty=1 next cycle; sticky flags unchanged; rst=0 mid-burst clears everything asynchronously.
